// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load alignment/extension, write-data
// select, registered forwarding copy of the last write and retired-instruction counter.
module wb_stage #(
   parameter int XLEN = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W = 64,
   localparam int AL_W = $clog2(XLEN / 8)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_flush,
   input  logic              i_pipe_Valid,
   input  logic [XLEN-1:0]   i_pipe_AluResult,
   input  logic [XLEN-1:0]   i_pipe_MemData,
   input  logic [XLEN-1:0]   i_pipe_PcPlus4,
   input  logic [1:0]        i_pipe_WbSel,
   input  logic [2:0]        i_pipe_LoadFunct3,
   input  logic [AL_W-1:0]   i_pipe_AddrLow,
   input  logic              i_pipe_RegWrEn,
   input  logic [REG_AW-1:0] i_pipe_RegDst,
   input  logic              i_CntWrEn,
   input  logic [CNT_W-1:0]  i_CntWrData,
   output logic [REG_AW-1:0] o_RegDst,
   output logic [XLEN-1:0]   o_RegWrData,
   output logic              o_RegWrEn,
   output logic              o_Retire,
   output logic [CNT_W-1:0]  o_InstRet,
   output logic              o_FwdValid,
   output logic [REG_AW-1:0] o_FwdDst,
   output logic [XLEN-1:0]   o_FwdData
);

   logic              wb_valid;
   logic [XLEN-1:0]   wb_alu;
   logic [XLEN-1:0]   wb_mem;
   logic [XLEN-1:0]   wb_pc4;
   logic [1:0]        wb_sel;
   logic [2:0]        wb_funct3;
   logic [AL_W-1:0]   wb_addr_low;
   logic              wb_reg_wr_en;
   logic [REG_AW-1:0] wb_dst;

   logic [AL_W-1:0]   half_off;
   logic [AL_W-1:0]   word_off;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [31:0]       ld_word;
   logic [XLEN-1:0]   load_data;
   logic [XLEN-1:0]   wr_data;
   logic              reg_wr_en;

   // A flush only clears valid; the payload is captured anyway since nothing reads it then.
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_valid     <= 1'b0;
         wb_alu       <= '0;
         wb_mem       <= '0;
         wb_pc4       <= '0;
         wb_sel       <= '0;
         wb_funct3    <= '0;
         wb_addr_low  <= '0;
         wb_reg_wr_en <= 1'b0;
         wb_dst       <= '0;
      end else begin
         wb_valid     <= i_pipe_Valid & ~i_flush;
         wb_alu       <= i_pipe_AluResult;
         wb_mem       <= i_pipe_MemData;
         wb_pc4       <= i_pipe_PcPlus4;
         wb_sel       <= i_pipe_WbSel;
         wb_funct3    <= i_pipe_LoadFunct3;
         wb_addr_low  <= i_pipe_AddrLow;
         wb_reg_wr_en <= i_pipe_RegWrEn;
         wb_dst       <= i_pipe_RegDst;
      end
   end

   // Misaligned offsets are silently rounded down to the access size.
   always_comb begin
      half_off  = wb_addr_low & ~AL_W'(1);
      word_off  = wb_addr_low & ~AL_W'(3);
      ld_byte   = wb_mem[{wb_addr_low, 3'b000} +: 8];
      ld_half   = wb_mem[{half_off, 3'b000} +: 16];
      ld_word   = wb_mem[{word_off, 3'b000} +: 32];
      load_data = wb_mem;
      case (wb_funct3)
         3'b000:  load_data = XLEN'($signed(ld_byte));
         3'b100:  load_data = XLEN'(ld_byte);
         3'b001:  load_data = XLEN'($signed(ld_half));
         3'b101:  load_data = XLEN'(ld_half);
         3'b010:  load_data = XLEN'($signed(ld_word));
         3'b110:  if (XLEN == 64) load_data = XLEN'(ld_word);
         default: load_data = wb_mem;
      endcase
   end

   always_comb begin
      case (wb_sel)
         2'd1:    wr_data = load_data;
         2'd2:    wr_data = wb_pc4;
         default: wr_data = wb_alu;
      endcase
      reg_wr_en = wb_valid & wb_reg_wr_en & (wb_dst != '0);
   end

   // A CSR write in the same cycle as a retire wins and the retire is not counted.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_InstRet <= '0;
      end else if (i_CntWrEn) begin
         o_InstRet <= i_CntWrData;
      end else if (wb_valid) begin
         o_InstRet <= o_InstRet + CNT_W'(1);
      end
   end

   // Holds an already-committed write, so a flush must not clear it.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_FwdValid <= 1'b0;
         o_FwdDst   <= '0;
         o_FwdData  <= '0;
      end else begin
         o_FwdValid <= reg_wr_en;
         o_FwdDst   <= wb_dst;
         o_FwdData  <= wr_data;
      end
   end

   assign o_RegDst    = wb_dst;
   assign o_RegWrData = wr_data;
   assign o_RegWrEn   = reg_wr_en;
   assign o_Retire    = wb_valid;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios on an RV32 (4-bit counter) and an
// RV64 instance, then randomized traffic against a behavioural reference model.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        valid;
   logic [63:0] alu;
   logic [63:0] mem;
   logic [63:0] pc4;
   logic [1:0]  wb_sel;
   logic [2:0]  funct3;
   logic [2:0]  addr_low;
   logic        reg_wr_en;
   logic [4:0]  dst;
   logic        cnt_wr_en;
   logic [63:0] cnt_data;

   logic [4:0]  a_dst;
   logic [31:0] a_data;
   logic        a_wr_en;
   logic        a_retire;
   logic [3:0]  a_inst_ret;
   logic        a_fwd_valid;
   logic [4:0]  a_fwd_dst;
   logic [31:0] a_fwd_data;

   logic [4:0]  b_dst;
   logic [63:0] b_data;
   logic        b_wr_en;
   logic        b_retire;
   logic [63:0] b_inst_ret;
   logic        b_fwd_valid;
   logic [4:0]  b_fwd_dst;
   logic [63:0] b_fwd_data;

   int errors = 0;
   int checks = 0;

   // Reference model state, index 0 = RV32/CNT_W=4 instance, 1 = RV64/CNT_W=64 instance.
   logic        m_valid[2];
   logic        m_wren[2];
   logic        m_known[2];
   logic [4:0]  m_dst[2];
   logic [63:0] m_data[2];
   logic        m_fwd_valid[2];
   logic        m_fwd_known[2];
   logic [4:0]  m_fwd_dst[2];
   logic [63:0] m_fwd_data[2];
   logic [63:0] m_cnt[2];

   always #5 clk = ~clk;

   wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(4)) u32 (
      .clk(clk), .reset(reset), .i_flush(flush),
      .i_pipe_Valid(valid), .i_pipe_AluResult(alu[31:0]), .i_pipe_MemData(mem[31:0]),
      .i_pipe_PcPlus4(pc4[31:0]), .i_pipe_WbSel(wb_sel), .i_pipe_LoadFunct3(funct3),
      .i_pipe_AddrLow(addr_low[1:0]), .i_pipe_RegWrEn(reg_wr_en), .i_pipe_RegDst(dst),
      .i_CntWrEn(cnt_wr_en), .i_CntWrData(cnt_data[3:0]),
      .o_RegDst(a_dst), .o_RegWrData(a_data), .o_RegWrEn(a_wr_en), .o_Retire(a_retire),
      .o_InstRet(a_inst_ret), .o_FwdValid(a_fwd_valid), .o_FwdDst(a_fwd_dst),
      .o_FwdData(a_fwd_data)
   );

   wb_stage #(.XLEN(64), .REG_AW(5), .CNT_W(64)) u64 (
      .clk(clk), .reset(reset), .i_flush(flush),
      .i_pipe_Valid(valid), .i_pipe_AluResult(alu), .i_pipe_MemData(mem),
      .i_pipe_PcPlus4(pc4), .i_pipe_WbSel(wb_sel), .i_pipe_LoadFunct3(funct3),
      .i_pipe_AddrLow(addr_low), .i_pipe_RegWrEn(reg_wr_en), .i_pipe_RegDst(dst),
      .i_CntWrEn(cnt_wr_en), .i_CntWrData(cnt_data),
      .o_RegDst(b_dst), .o_RegWrData(b_data), .o_RegWrEn(b_wr_en), .o_Retire(b_retire),
      .o_InstRet(b_inst_ret), .o_FwdValid(b_fwd_valid), .o_FwdDst(b_fwd_dst),
      .o_FwdData(b_fwd_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic v, input logic [1:0] s, input logic [4:0] d,
                            input logic [63:0] a_val);
      valid     = v;
      wb_sel    = s;
      dst       = d;
      alu       = a_val;
      reg_wr_en = 1'b1;
   endtask

   // Load result from the ISA definition: pick bytes by offset, then extend arithmetically.
   function automatic logic [63:0] load_ext(input logic [63:0] m_in, input logic [2:0] f3,
                                            input int off, input int xl);
      logic [63:0] mask;
      logic [63:0] m;
      logic [63:0] b;
      logic [63:0] h;
      logic [63:0] w;
      int hoff;
      int woff;
      mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      m    = m_in & mask;
      hoff = off - (off % 2);
      woff = off - (off % 4);
      b    = (m >> (8 * off)) & 64'hFF;
      h    = (m >> (8 * hoff)) & 64'hFFFF;
      w    = (m >> (8 * woff)) & 64'hFFFF_FFFF;
      case (f3)
         3'd0:    return (b >= 64'd128) ? ((b - 64'd256) & mask) : b;
         3'd4:    return b;
         3'd1:    return (h >= 64'd32768) ? ((h - 64'd65536) & mask) : h;
         3'd5:    return h;
         3'd2:    return (w >= 64'h8000_0000) ? ((w - 64'h1_0000_0000) & mask) : w;
         3'd6:    return (xl == 64) ? w : m;
         default: return m;
      endcase
   endfunction

   task automatic model_edge(input int k);
      logic [63:0] mask;
      logic [63:0] cmask;
      logic [63:0] wd;
      int          off;
      mask  = (k == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      cmask = (k == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hF;
      off   = (k == 1) ? int'(addr_low) : int'(addr_low[1:0]);
      if (wb_sel == 2'd1) wd = load_ext(mem, funct3, off, (k == 1) ? 64 : 32);
      else if (wb_sel == 2'd2) wd = pc4 & mask;
      else wd = alu & mask;
      if (reset) begin
         m_valid[k] = 0; m_wren[k] = 0; m_known[k] = 1; m_dst[k] = 0; m_data[k] = 0;
         m_fwd_valid[k] = 0; m_fwd_known[k] = 1; m_fwd_dst[k] = 0; m_fwd_data[k] = 0;
         m_cnt[k] = 0;
      end else begin
         m_fwd_valid[k] = m_wren[k];
         m_fwd_known[k] = m_known[k];
         m_fwd_dst[k]   = m_dst[k];
         m_fwd_data[k]  = m_data[k];
         if (cnt_wr_en) m_cnt[k] = cnt_data & cmask;
         else if (m_valid[k]) m_cnt[k] = (m_cnt[k] + 1) & cmask;
         if (flush) begin
            m_valid[k] = 0; m_wren[k] = 0; m_known[k] = 0;
         end else begin
            m_valid[k] = valid;
            m_wren[k]  = valid & reg_wr_en & (dst != 0);
            m_dst[k]   = dst;
            m_data[k]  = wd;
            m_known[k] = 1;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         valid = 1'($urandom); flush = 1'($urandom); reg_wr_en = 1'b1;
         alu = {$urandom, $urandom}; mem = {$urandom, $urandom}; pc4 = {$urandom, $urandom};
         wb_sel = 2'($urandom); funct3 = 3'($urandom); addr_low = 3'($urandom);
         dst = 5'($urandom_range(1, 31)); cnt_wr_en = 1'($urandom);
         cnt_data = {$urandom, $urandom};
         tick();
      end
      checks++;
      if ({a_dst, a_data, a_wr_en, a_retire, a_inst_ret, a_fwd_valid, a_fwd_dst, a_fwd_data} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs_32: got dst=%h data=%h we=%b ret=%b cnt=%h fv=%b fd=%h fdata=%h expected all zero",
                  a_dst, a_data, a_wr_en, a_retire, a_inst_ret, a_fwd_valid, a_fwd_dst, a_fwd_data);
      end
      checks++;
      if ({b_dst, b_data, b_wr_en, b_retire, b_inst_ret, b_fwd_valid, b_fwd_dst, b_fwd_data} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs_64: got dst=%h data=%h we=%b ret=%b cnt=%h fv=%b fd=%h fdata=%h expected all zero",
                  b_dst, b_data, b_wr_en, b_retire, b_inst_ret, b_fwd_valid, b_fwd_dst, b_fwd_data);
      end
      reset = 1'b0; flush = 1'b0; cnt_wr_en = 1'b0;
      set_instr(1'b1, 2'd0, 5'd5, 64'h1234);
      tick();
      checks++;
      if ({a_wr_en, a_dst, a_data} !== {1'b1, 5'd5, 32'h1234}) begin
         errors++;
         $display("[TB] FAIL first_write_32: got we=%b dst=%0d data=%h expected we=1 dst=5 data=1234", a_wr_en, a_dst, a_data);
      end
      checks++;
      if ({b_wr_en, b_dst, b_data} !== {1'b1, 5'd5, 64'h1234}) begin
         errors++;
         $display("[TB] FAIL first_write_64: got we=%b dst=%0d data=%h expected we=1 dst=5 data=1234", b_wr_en, b_dst, b_data);
      end
      valid = 1'b0;
      tick();
      checks++;
      if ({a_fwd_valid, a_fwd_dst, a_fwd_data, a_inst_ret} !== {1'b1, 5'd5, 32'h1234, 4'd1}) begin
         errors++;
         $display("[TB] FAIL first_fwd_32: got fv=%b fd=%0d fdata=%h cnt=%0d expected fv=1 fd=5 fdata=1234 cnt=1",
                  a_fwd_valid, a_fwd_dst, a_fwd_data, a_inst_ret);
      end
      checks++;
      if ({b_fwd_valid, b_fwd_dst, b_fwd_data, b_inst_ret} !== {1'b1, 5'd5, 64'h1234, 64'd1}) begin
         errors++;
         $display("[TB] FAIL first_fwd_64: got fv=%b fd=%0d fdata=%h cnt=%0d expected fv=1 fd=5 fdata=1234 cnt=1",
                  b_fwd_valid, b_fwd_dst, b_fwd_data, b_inst_ret);
      end
   endtask

   task automatic test_load32();
      logic [2:0]  f3s[5]  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
      logic [2:0]  offs[5] = '{3'd3, 3'd1, 3'd2, 3'd0, 3'd0};
      logic [31:0] exps[5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
      mem = 64'h80FF_7F01;
      for (int i = 0; i < 5; i++) begin
         set_instr(1'b1, 2'd1, 5'd9, 64'h0);
         funct3 = f3s[i]; addr_low = offs[i];
         tick();
         checks++;
         if (a_data !== exps[i]) begin
            errors++;
            $display("[TB] FAIL load32_f3_%0d_off_%0d: got %h expected %h", f3s[i], offs[i], a_data, exps[i]);
         end
      end
      valid = 1'b0;
      tick();
   endtask

   task automatic test_x0_link();
      valid = 1'b0; cnt_wr_en = 1'b1; cnt_data = 64'd2;
      tick();
      cnt_wr_en = 1'b0;
      set_instr(1'b1, 2'd0, 5'd0, 64'hDEAD);
      tick();
      checks++;
      if ({a_wr_en, a_retire, a_inst_ret} !== {1'b0, 1'b1, 4'd2}) begin
         errors++;
         $display("[TB] FAIL x0_write_32: got we=%b ret=%b cnt=%0d expected we=0 ret=1 cnt=2", a_wr_en, a_retire, a_inst_ret);
      end
      set_instr(1'b1, 2'd2, 5'd7, 64'hBEEF);
      pc4 = 64'h104;
      tick();
      checks++;
      if ({a_wr_en, a_data, a_inst_ret} !== {1'b1, 32'h104, 4'd3}) begin
         errors++;
         $display("[TB] FAIL link_32: got we=%b data=%h cnt=%0d expected we=1 data=104 cnt=3", a_wr_en, a_data, a_inst_ret);
      end
      checks++;
      if ({b_wr_en, b_data, b_inst_ret} !== {1'b1, 64'h104, 64'd3}) begin
         errors++;
         $display("[TB] FAIL link_64: got we=%b data=%h cnt=%0d expected we=1 data=104 cnt=3", b_wr_en, b_data, b_inst_ret);
      end
      valid = 1'b0;
      tick();
      checks++;
      if (a_inst_ret !== 4'd4) begin
         errors++;
         $display("[TB] FAIL x0_link_count_32: got %0d expected 4", a_inst_ret);
      end
   endtask

   task automatic test_flush();
      cnt_wr_en = 1'b1; cnt_data = 64'd0;
      set_instr(1'b1, 2'd0, 5'd3, 64'hAAAA);
      tick();
      cnt_wr_en = 1'b0;
      set_instr(1'b1, 2'd0, 5'd4, 64'hBBBB);
      flush = 1'b1;
      tick();
      flush = 1'b0; valid = 1'b0;
      checks++;
      if ({a_wr_en, a_retire} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL flush_kill_32: got we=%b ret=%b expected we=0 ret=0", a_wr_en, a_retire);
      end
      checks++;
      if ({a_fwd_valid, a_fwd_dst, a_fwd_data, a_inst_ret} !== {1'b1, 5'd3, 32'hAAAA, 4'd1}) begin
         errors++;
         $display("[TB] FAIL flush_commit_32: got fv=%b fd=%0d fdata=%h cnt=%0d expected fv=1 fd=3 fdata=aaaa cnt=1",
                  a_fwd_valid, a_fwd_dst, a_fwd_data, a_inst_ret);
      end
      tick();
      checks++;
      if ({a_fwd_valid, a_inst_ret, b_fwd_valid, b_inst_ret} !== {1'b0, 4'd1, 1'b0, 64'd1}) begin
         errors++;
         $display("[TB] FAIL flush_after_32_64: got fv=%b cnt=%0d fv64=%b cnt64=%0d expected fv=0 cnt=1",
                  a_fwd_valid, a_inst_ret, b_fwd_valid, b_inst_ret);
      end
   endtask

   task automatic test_counter();
      cnt_wr_en = 1'b1; cnt_data = 64'hF;
      set_instr(1'b1, 2'd0, 5'd1, 64'h1);
      tick();
      cnt_wr_en = 1'b0; valid = 1'b0;
      tick();
      checks++;
      if (a_inst_ret !== 4'h0) begin
         errors++;
         $display("[TB] FAIL count_wrap_4: got %h expected 0", a_inst_ret);
      end
      checks++;
      if (b_inst_ret !== 64'h10) begin
         errors++;
         $display("[TB] FAIL count_no_wrap_64: got %h expected 10", b_inst_ret);
      end
      valid = 1'b1;
      tick();
      valid = 1'b0; cnt_wr_en = 1'b1; cnt_data = 64'h7;
      tick();
      cnt_wr_en = 1'b0;
      checks++;
      if ({a_inst_ret, b_inst_ret} !== {4'h7, 64'h7}) begin
         errors++;
         $display("[TB] FAIL count_write_beats_retire: got %h / %h expected 7 / 7", a_inst_ret, b_inst_ret);
      end
      tick();
      checks++;
      if (a_inst_ret !== 4'h7) begin
         errors++;
         $display("[TB] FAIL count_hold: got %h expected 7", a_inst_ret);
      end
   endtask

   task automatic test_load64();
      logic [2:0]  f3s[3]  = '{3'd6, 3'd2, 3'd3};
      logic [63:0] exps[3] = '{64'h0000_0000_FEDC_BA98, 64'hFFFF_FFFF_FEDC_BA98, 64'hFEDC_BA98_7654_3210};
      mem = 64'hFEDC_BA98_7654_3210; addr_low = 3'd4;
      for (int i = 0; i < 3; i++) begin
         set_instr(1'b1, 2'd1, 5'd12, 64'h0);
         funct3 = f3s[i];
         tick();
         checks++;
         if (b_data !== exps[i]) begin
            errors++;
            $display("[TB] FAIL load64_f3_%0d: got %h expected %h", f3s[i], b_data, exps[i]);
         end
         checks++;
         if (a_data !== 32'h7654_3210) begin
            errors++;
            $display("[TB] FAIL load32_f3_%0d_raw: got %h expected 76543210", f3s[i], a_data);
         end
      end
      valid = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      cnt_wr_en = 1'b1; cnt_data = 64'd0;
      for (int i = 1; i <= 4; i++) begin
         set_instr(1'b1, 2'd0, 5'(i), 64'(i * 16'h111));
         tick();
         cnt_wr_en = 1'b0;
         checks++;
         if ({a_retire, a_dst, a_data, a_inst_ret} !== {1'b1, 5'(i), 32'(i * 16'h111), 4'(i - 1)}) begin
            errors++;
            $display("[TB] FAIL b2b_%0d: got ret=%b dst=%0d data=%h cnt=%0d expected ret=1 dst=%0d data=%h cnt=%0d",
                     i, a_retire, a_dst, a_data, a_inst_ret, i, i * 16'h111, i - 1);
         end
      end
      valid = 1'b0;
      tick();
   endtask

   task automatic test_random();
      logic        o_wr, o_ret, o_fv;
      logic [4:0]  o_dst, o_fdst;
      logic [63:0] o_data, o_fdata, o_cnt;
      reset = 1'b1;
      tick();
      model_edge(0); model_edge(1);
      reset = 1'b0;
      for (int n = 0; n < 400; n++) begin
         reset     = ($urandom_range(0, 49) == 0);
         flush     = ($urandom_range(0, 7) == 0);
         valid     = ($urandom_range(0, 3) != 0);
         alu       = {$urandom, $urandom};
         mem       = {$urandom, $urandom};
         pc4       = {$urandom, $urandom};
         wb_sel    = 2'($urandom);
         funct3    = 3'($urandom);
         addr_low  = 3'($urandom);
         reg_wr_en = ($urandom_range(0, 4) != 0);
         dst       = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
         cnt_wr_en = ($urandom_range(0, 15) == 0);
         cnt_data  = {$urandom, $urandom};
         tick();
         for (int k = 0; k < 2; k++) begin
            model_edge(k);
            if (k == 0) begin
               o_wr = a_wr_en; o_ret = a_retire; o_fv = a_fwd_valid; o_dst = a_dst; o_fdst = a_fwd_dst;
               o_data = {32'h0, a_data}; o_fdata = {32'h0, a_fwd_data}; o_cnt = {60'h0, a_inst_ret};
            end else begin
               o_wr = b_wr_en; o_ret = b_retire; o_fv = b_fwd_valid; o_dst = b_dst; o_fdst = b_fwd_dst;
               o_data = b_data; o_fdata = b_fwd_data; o_cnt = b_inst_ret;
            end
            checks++;
            if ({o_wr, o_ret, o_fv, o_cnt} !== {m_wren[k], m_valid[k], m_fwd_valid[k], m_cnt[k]}) begin
               errors++;
               $display("[TB] FAIL rand_ctrl_dut%0d_cyc%0d: got we=%b ret=%b fv=%b cnt=%h expected we=%b ret=%b fv=%b cnt=%h",
                        k, n, o_wr, o_ret, o_fv, o_cnt, m_wren[k], m_valid[k], m_fwd_valid[k], m_cnt[k]);
            end
            if (m_known[k]) begin
               checks++;
               if ({o_dst, o_data} !== {m_dst[k], m_data[k]}) begin
                  errors++;
                  $display("[TB] FAIL rand_wb_dut%0d_cyc%0d: got dst=%0d data=%h expected dst=%0d data=%h",
                           k, n, o_dst, o_data, m_dst[k], m_data[k]);
               end
            end
            if (m_fwd_known[k]) begin
               checks++;
               if ({o_fdst, o_fdata} !== {m_fwd_dst[k], m_fwd_data[k]}) begin
                  errors++;
                  $display("[TB] FAIL rand_fwd_dut%0d_cyc%0d: got dst=%0d data=%h expected dst=%0d data=%h",
                           k, n, o_fdst, o_fdata, m_fwd_dst[k], m_fwd_data[k]);
               end
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; valid = 1'b0; alu = '0; mem = '0; pc4 = '0;
      wb_sel = '0; funct3 = '0; addr_low = '0; reg_wr_en = 1'b0; dst = '0;
      cnt_wr_en = 1'b0; cnt_data = '0;
      test_reset();
      test_load32();
      test_x0_link();
      test_flush();
      test_counter();
      test_load64();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
